// File: rtl/riscv_control_fsm.sv
// Multicycle RV32I control FSM: sequences fetch, decode, execute and writeback,
// driving ALU operand selects, ALU operation and all datapath write strobes.
package riscv_control_pkg;
  typedef enum logic [1:0] {
    LESS    = 2'd0,
    EQUAL   = 2'd1,
    GREATER = 2'd2
  } alu_comp_t;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_SLL  = 4'd2,
    ALU_SLT  = 4'd3,
    ALU_SLTU = 4'd4,
    ALU_XOR  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_OR   = 4'd8,
    ALU_AND  = 4'd9,
    ALU_SRC2 = 4'd10
  } alu_ctrl_t;
endpackage

module riscv_control_fsm
  import riscv_control_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instr,
  input  alu_comp_t   ALU_comp,
  output logic [1:0]  ALU_src1_sel,
  output logic [1:0]  ALU_src2_sel,
  output alu_ctrl_t   ALU_ctrl,
  output logic        IR_write,
  output logic        PC_write,
  output logic        pc_src_sel,
  output logic        reg_write,
  output logic [1:0]  result_sel,
  output logic        mem_addr_sel,
  output logic        mem_write,
  output logic        instr_retired,
  output logic        halted
);

  typedef enum logic [3:0] {
    FETCH     = 4'd0,
    LATCH     = 4'd1,
    DECODE    = 4'd2,
    EXEC_R    = 4'd3,
    EXEC_I    = 4'd4,
    ALU_WB    = 4'd5,
    MEM_ADDR  = 4'd6,
    LOAD_REQ  = 4'd7,
    LOAD_WB   = 4'd8,
    STORE     = 4'd9,
    BRANCH    = 4'd10,
    JALR_CALC = 4'd11,
    JUMP      = 4'd12,
    LUI       = 4'd13,
    AUIPC     = 4'd14,
    TRAP      = 4'd15
  } state_t;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  state_t state, next_state;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       unused_instr_bits;

  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign funct7 = instr[31:25];
  assign unused_instr_bits = ^{instr[24:15], instr[11:7]};

  function automatic alu_ctrl_t alu_op(input logic [2:0] f3, input logic alt);
    case (f3)
      3'b000:  return alt ? ALU_SUB : ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLT;
      3'b011:  return ALU_SLTU;
      3'b100:  return ALU_XOR;
      3'b101:  return alt ? ALU_SRA : ALU_SRL;
      3'b110:  return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

  logic r_legal, i_legal, load_legal, store_legal, branch_legal, branch_taken;

  always_comb begin
    r_legal      = (funct7 == 7'b0000000) ||
                   (funct7 == 7'b0100000 && (funct3 == 3'b000 || funct3 == 3'b101));
    i_legal      = 1'b1;
    if (funct3 == 3'b001) i_legal = (funct7 == 7'b0000000);
    if (funct3 == 3'b101) i_legal = (funct7 == 7'b0000000) || (funct7 == 7'b0100000);
    load_legal   = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010) ||
                   (funct3 == 3'b100) || (funct3 == 3'b101);
    store_legal  = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010);
    branch_legal = (funct3[2:1] != 2'b01);
    case (funct3)
      3'b000:         branch_taken = (ALU_comp == EQUAL);
      3'b001:         branch_taken = (ALU_comp != EQUAL);
      3'b100, 3'b110: branch_taken = (ALU_comp == LESS);
      3'b101, 3'b111: branch_taken = (ALU_comp != LESS);
      default:        branch_taken = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= FETCH;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      FETCH:  next_state = LATCH;
      LATCH:  next_state = DECODE;
      DECODE: begin
        case (opcode)
          OP_R:              next_state = EXEC_R;
          OP_I:              next_state = EXEC_I;
          OP_LOAD, OP_STORE: next_state = MEM_ADDR;
          OP_BRANCH:         next_state = BRANCH;
          OP_JAL:            next_state = JUMP;
          OP_JALR:           next_state = JALR_CALC;
          OP_LUI:            next_state = LUI;
          OP_AUIPC:          next_state = AUIPC;
          default:           next_state = TRAP;
        endcase
      end
      EXEC_R:    next_state = r_legal ? ALU_WB : TRAP;
      EXEC_I:    next_state = i_legal ? ALU_WB : TRAP;
      MEM_ADDR: begin
        if (opcode == OP_LOAD) next_state = load_legal ? LOAD_REQ : TRAP;
        else                   next_state = store_legal ? STORE : TRAP;
      end
      LOAD_REQ:  next_state = LOAD_WB;
      BRANCH:    next_state = branch_legal ? FETCH : TRAP;
      JALR_CALC: next_state = JUMP;
      TRAP:      next_state = TRAP;
      default:   next_state = FETCH;
    endcase
  end

  always_comb begin
    ALU_src1_sel  = 2'd0;
    ALU_src2_sel  = 2'd0;
    ALU_ctrl      = ALU_ADD;
    IR_write      = 1'b0;
    PC_write      = 1'b0;
    pc_src_sel    = 1'b0;
    reg_write     = 1'b0;
    result_sel    = 2'd0;
    mem_addr_sel  = 1'b0;
    mem_write     = 1'b0;
    instr_retired = 1'b0;
    halted        = 1'b0;
    case (state)
      LATCH: begin
        IR_write     = 1'b1;
        ALU_src2_sel = 2'd2;
        PC_write     = 1'b1;
      end
      DECODE: begin
        ALU_src1_sel = 2'd1;
        ALU_src2_sel = 2'd1;
      end
      EXEC_R: begin
        ALU_src1_sel = 2'd2;
        ALU_ctrl     = alu_op(funct3, funct7[5]);
      end
      EXEC_I: begin
        ALU_src1_sel = 2'd2;
        ALU_src2_sel = 2'd1;
        ALU_ctrl     = alu_op(funct3, (funct3 != 3'b000) && funct7[5]);
      end
      ALU_WB, AUIPC: begin
        reg_write     = 1'b1;
        instr_retired = 1'b1;
      end
      MEM_ADDR, JALR_CALC: begin
        ALU_src1_sel = 2'd2;
        ALU_src2_sel = 2'd1;
      end
      LOAD_REQ: mem_addr_sel = 1'b1;
      LOAD_WB: begin
        reg_write     = 1'b1;
        result_sel    = 2'd1;
        instr_retired = 1'b1;
      end
      STORE: begin
        mem_addr_sel  = 1'b1;
        mem_write     = 1'b1;
        instr_retired = 1'b1;
      end
      BRANCH: begin
        ALU_src1_sel  = 2'd2;
        ALU_ctrl      = (funct3[2:1] == 2'b11) ? ALU_SLTU : ALU_SLT;
        // An illegal branch funct3 traps without touching the PC or retiring.
        PC_write      = branch_legal && branch_taken;
        pc_src_sel    = branch_legal && branch_taken;
        instr_retired = branch_legal;
      end
      JUMP: begin
        ALU_src1_sel  = 2'd1;
        ALU_src2_sel  = 2'd2;
        reg_write     = 1'b1;
        result_sel    = 2'd2;
        PC_write      = 1'b1;
        pc_src_sel    = 1'b1;
        instr_retired = 1'b1;
      end
      LUI: begin
        ALU_src2_sel  = 2'd1;
        ALU_ctrl      = ALU_SRC2;
        reg_write     = 1'b1;
        result_sel    = 2'd2;
        instr_retired = 1'b1;
      end
      TRAP:    halted = 1'b1;
      default: ;
    endcase
    if (reset) begin
      IR_write      = 1'b0;
      PC_write      = 1'b0;
      reg_write     = 1'b0;
      mem_write     = 1'b0;
      instr_retired = 1'b0;
    end
  end

endmodule
